// File: rtl/fetch_entry_buffer_pkg.sv
// Shared types for the fetch entry buffer.
// fetch_entry_t is the frontend-to-decode payload; its packed width sets the
// default entry width of the buffer.
package fetch_entry_buffer_pkg;

  typedef struct packed {
    logic [63:0] address;          // virtual PC of the instruction
    logic [31:0] instruction;      // realigned (possibly compressed) instruction
    logic [31:0] branch_info;      // branch prediction / exception side-band
  } fetch_entry_t;

  localparam int unsigned FetchEntryWidth = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_entry_buffer_mem.sv
// Register array holding the buffered fetch entries.
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : one read address per read port
//   rdata_o  : combinational read data per read port
// Contents are deliberately not reset; the occupancy count decides validity.
module fetch_entry_buffer_mem #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned EntryWidth  = 128,
  parameter int unsigned NrReadPorts = 1,
  parameter int unsigned AddrW       = $clog2(Depth)
) (
  input  logic                                     clk_i,
  input  logic                                     we_i,
  input  logic [AddrW-1:0]                         waddr_i,
  input  logic [EntryWidth-1:0]                    wdata_i,
  input  logic [NrReadPorts-1:0][AddrW-1:0]        raddr_i,
  output logic [NrReadPorts-1:0][EntryWidth-1:0]   rdata_o
);

  logic [EntryWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned k = 0; k < NrReadPorts; k++) begin
      rdata_o[k] = mem_q[raddr_i[k]];
    end
  end

endmodule

// File: rtl/fetch_entry_buffer.sv
// Elastic in-order buffer between the instruction realigner and decode.
// Ports:
//   clk_i               : clock
//   rst_i               : synchronous active-high reset
//   flush_i             : discard all contents (takes effect next cycle)
//   fetch_entry_i       : entry from the frontend
//   fetch_entry_valid_i : frontend valid
//   fetch_entry_ready_o : buffer can accept an entry (registered state only)
//   fetch_entry_o       : port k carries the k-th oldest entry
//   fetch_entry_valid_o : per-port valid
//   fetch_entry_ready_i : per-port decode accept
//   count_o             : current occupancy
module fetch_entry_buffer
  import fetch_entry_buffer_pkg::*;
#(
  parameter int unsigned NrIssuePorts = 1,
  parameter int unsigned Depth        = 4,
  parameter int unsigned EntryWidth   = FetchEntryWidth,
  parameter int unsigned CntW         = $clog2(Depth + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [EntryWidth-1:0]                   fetch_entry_i,
  input  logic                                    fetch_entry_valid_i,
  output logic                                    fetch_entry_ready_o,
  output logic [NrIssuePorts-1:0][EntryWidth-1:0] fetch_entry_o,
  output logic [NrIssuePorts-1:0]                 fetch_entry_valid_o,
  input  logic [NrIssuePorts-1:0]                 fetch_entry_ready_i,
  output logic [CntW-1:0]                         count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0]                   rptr_q, wptr_q;
  logic [CntW-1:0]                   count_q;
  logic                              push;
  logic [NrIssuePorts-1:0]           pop;
  logic [CntW-1:0]                   pop_cnt;
  logic [NrIssuePorts-1:0][PtrW-1:0] raddr;
  logic                              in_order;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens a slot early and there is no path from fetch_entry_ready_i.
  assign fetch_entry_ready_o = (count_q < CntW'(Depth));
  assign push    = fetch_entry_valid_i & fetch_entry_ready_o & ~flush_i;
  assign count_o = count_q;

  // A port only pops when every older port pops too, keeping issue in order.
  always_comb begin
    fetch_entry_valid_o = '0;
    pop                 = '0;
    pop_cnt             = '0;
    raddr               = '0;
    in_order            = 1'b1;
    for (int unsigned k = 0; k < NrIssuePorts; k++) begin
      raddr[k]               = rptr_q + PtrW'(k);
      fetch_entry_valid_o[k] = (count_q > CntW'(k)) & ~flush_i;
      pop[k]                 = in_order & fetch_entry_valid_o[k] & fetch_entry_ready_i[k];
      in_order               = pop[k];
      pop_cnt                = pop_cnt + CntW'(pop[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_q + PtrW'(pop_cnt);
      wptr_q  <= wptr_q + PtrW'(push);
      count_q <= count_q + CntW'(push) - pop_cnt;
    end
  end

  fetch_entry_buffer_mem #(
    .Depth       (Depth),
    .EntryWidth  (EntryWidth),
    .NrReadPorts (NrIssuePorts),
    .AddrW       (PtrW)
  ) i_mem (
    .clk_i   (clk_i),
    .we_i    (push & ~rst_i),
    .waddr_i (wptr_q),
    .wdata_i (fetch_entry_i),
    .raddr_i (raddr),
    .rdata_o (fetch_entry_o)
  );

  a_params : assert property (@(posedge clk_i)
    (NrIssuePorts inside {1, 2}) && (Depth >= 2) && ((Depth & (Depth - 1)) == 0));

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (count_q != CntW'(Depth)));

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CntW'(Depth));

endmodule

// File: tb/tb_fetch_entry_buffer.sv
// Self-checking bench for fetch_entry_buffer: directed scenarios followed by
// random traffic, checked by a queue-based reference model in a monitor.
module tb_fetch_entry_buffer;

  localparam int unsigned NP = 2;
  localparam int unsigned DP = 4;
  localparam int unsigned EW = 128;
  localparam int unsigned CW = $clog2(DP + 1);

  logic                   clk;
  logic                   rst_i;
  logic                   flush_i;
  logic [EW-1:0]          entry_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [NP-1:0][EW-1:0]  entry_o;
  logic [NP-1:0]          valid_o;
  logic [NP-1:0]          ready_i;
  logic [CW-1:0]          count_o;

  int checks = 0;
  int fails  = 0;

  fetch_entry_buffer #(
    .NrIssuePorts (NP),
    .Depth        (DP),
    .EntryWidth   (EW)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .fetch_entry_i       (entry_i),
    .fetch_entry_valid_i (valid_i),
    .fetch_entry_ready_o (ready_o),
    .fetch_entry_o       (entry_o),
    .fetch_entry_valid_o (valid_o),
    .fetch_entry_ready_i (ready_i),
    .count_o             (count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the buffer is an ordered list of accepted entries.
  logic [EW-1:0] model_q[$];
  bit            known = 1'b0;

  always @(negedge clk) begin
    int unsigned sz;
    int unsigned npop;
    bit          exp_v;
    sz = model_q.size();
    if (known) begin
      chk("count_o", EW'(count_o), EW'(sz));
      chk("ready_o", EW'(ready_o), EW'(sz < DP));
      for (int unsigned k = 0; k < NP; k++) begin
        exp_v = (sz > k) && !flush_i;
        chk($sformatf("valid_o[%0d]", k), EW'(valid_o[k]), EW'(exp_v));
        if (exp_v) chk($sformatf("entry_o[%0d]", k), entry_o[k], model_q[k]);
      end
    end
    if (rst_i) begin
      model_q.delete();
      known = 1'b1;
    end else if (known) begin
      if (flush_i) begin
        model_q.delete();
      end else begin
        npop = 0;
        if (sz > 0 && ready_i[0]) npop = 1;
        if (npop == 1 && sz > 1 && ready_i[1]) npop = 2;
        repeat (npop) void'(model_q.pop_front());
        if (valid_i && sz < DP) model_q.push_back(entry_i);
      end
    end
  end

  task automatic cyc(input logic v, input logic [EW-1:0] d, input logic [NP-1:0] r,
                     input logic f, input logic rs);
    valid_i = v;
    entry_i = d;
    ready_i = r;
    flush_i = f;
    rst_i   = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] rnd_entry();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [EW-1:0] ea, eb, ec, ed, ee, ef;

  initial begin
    ea = {4{32'hAAAA_0001}};
    eb = {4{32'hBBBB_0002}};
    ec = {4{32'hCCCC_0003}};
    ed = {4{32'hDDDD_0004}};
    ee = {4{32'hEEEE_0005}};
    ef = {4{32'hF00F_0006}};

    // Reset, then A,B,C with decode stalled
    cyc(0, '0, 2'b00, 0, 1);
    cyc(0, '0, 2'b00, 0, 1);
    cyc(1, ea, 2'b00, 0, 0);
    cyc(1, eb, 2'b00, 0, 0);
    cyc(1, ec, 2'b00, 0, 0);
    cyc(0, '0, 2'b00, 0, 0);

    // Fill, hold E while full, pop A, then E accepted
    cyc(1, ed, 2'b00, 0, 0);
    cyc(1, ee, 2'b00, 0, 0);
    cyc(1, ee, 2'b00, 0, 0);
    cyc(1, ee, 2'b01, 0, 0);
    cyc(1, ee, 2'b00, 0, 0);
    cyc(0, '0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 2'b11, 0, 0);

    // Port 1 ready without port 0 must not pop
    cyc(1, ea, 2'b00, 0, 0);
    cyc(1, eb, 2'b00, 0, 0);
    cyc(0, '0, 2'b10, 0, 0);
    cyc(0, '0, 2'b11, 0, 0);
    cyc(0, '0, 2'b00, 0, 0);

    // Wrap-around streaming through port 0
    for (int i = 0; i < 10; i++) cyc(1, EW'(i), 2'b01, 0, 0);
    cyc(0, '0, 2'b01, 0, 0);
    cyc(0, '0, 2'b00, 0, 0);

    // Flush with a concurrent push and pop
    cyc(1, ea, 2'b00, 0, 0);
    cyc(1, eb, 2'b00, 0, 0);
    cyc(1, ec, 2'b00, 0, 0);
    cyc(1, ed, 2'b11, 1, 0);
    cyc(0, '0, 2'b11, 0, 0);

    // Reset mid-stream, then F
    cyc(1, ea, 2'b00, 0, 0);
    cyc(1, eb, 2'b00, 0, 0);
    cyc(1, ec, 2'b00, 0, 1);
    cyc(1, ef, 2'b00, 0, 0);
    cyc(0, '0, 2'b01, 0, 0);
    cyc(0, '0, 2'b00, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(3, 0) != 0), rnd_entry(), NP'($urandom_range(3, 0)),
          ($urandom_range(19, 0) == 0), ($urandom_range(59, 0) == 0));
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, 2'b11, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
